// File: rtl/io_uart_pkg.sv
// Shared types and helpers for the IO UART blocks.
//   INPUT_CONTROLLER_STATE : receiver FSM state encoding
//   calc_tick_div()        : oversampling tick divider, rounded, never below 1
package io_uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } INPUT_CONTROLLER_STATE;

  function automatic int unsigned calc_tick_div(input int unsigned clk_freq,
                                                input int unsigned baud,
                                                input int unsigned oversample);
    int unsigned den;
    int unsigned div;
    den = baud * oversample;
    div = (clk_freq + den / 2) / den;
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/io_rx_tick_generator.sv
// Free-running oversampling tick divider.
//   clk     : system clock
//   reset   : asynchronous active-high reset
//   restart : clear the divider so the next tick lands TICK_DIV clk later
//   tick    : one-clk pulse every TICK_DIV clk
module io_rx_tick_generator #(
  parameter int unsigned TICK_DIV = 54
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || (cnt == CntLast)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With TICK_DIV == 1 this is permanently high: every clk is a tick.
  assign tick = (cnt == CntLast);

endmodule

// File: rtl/io_input_controller.sv
// UART receiver (8N1, LSB first) feeding the CPU IO bus via a valid/ack holding register.
//   clk                  : system clock
//   reset                : asynchronous active-high reset
//   TXD                  : serial line from host, idle high, asynchronous to clk
//   io_input_value       : last received byte, stable while io_input_valid is high
//   io_input_valid       : a byte is waiting in the holding register
//   io_input_ack         : consumer takes the byte (ignored while valid is low)
//   io_input_overrun     : sticky, a byte was dropped because the holding register was full
//   io_input_frame_error : sticky, a stop bit was sampled low
module io_input_controller
  import io_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TXD,
  output logic [7:0] io_input_value,
  output logic       io_input_valid,
  input  logic       io_input_ack,
  output logic       io_input_overrun,
  output logic       io_input_frame_error
);

  localparam int unsigned TickDiv = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CntW    = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(OVERSAMPLE - 1);

  INPUT_CONTROLLER_STATE state;

  logic            rx_meta;
  logic            line;
  logic            tick;
  logic            restart;
  logic [CntW-1:0] tick_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            wait_high;  // line was low at a bad stop bit; wait for it to rise
  logic            commit;     // good stop bit seen last clk, hand shift to holding reg

  // Two-flop synchronizer, preset to the idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      line    <= 1'b1;
    end else begin
      rx_meta <= TXD;
      line    <= rx_meta;
    end
  end

  // Re-phase the tick divider on the detected start-bit edge.
  assign restart = (state == RX_IDLE) && !wait_high && !line;

  io_rx_tick_generator #(
    .TICK_DIV(TickDiv)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= RX_IDLE;
      tick_cnt             <= '0;
      bit_idx              <= '0;
      shift                <= '0;
      wait_high            <= 1'b0;
      commit               <= 1'b0;
      io_input_value       <= '0;
      io_input_valid       <= 1'b0;
      io_input_overrun     <= 1'b0;
      io_input_frame_error <= 1'b0;
    end else begin
      commit <= 1'b0;

      // Holding register. Placed ahead of the FSM so a frame error raised by
      // the FSM in the same clk overrides the clear from an ack.
      if (commit) begin
        if (!io_input_valid || io_input_ack) begin
          io_input_value <= shift;
          io_input_valid <= 1'b1;
        end else begin
          io_input_overrun <= 1'b1;
        end
      end else if (io_input_valid && io_input_ack) begin
        io_input_valid       <= 1'b0;
        io_input_overrun     <= 1'b0;
        io_input_frame_error <= 1'b0;
      end

      unique case (state)
        RX_IDLE: begin
          if (wait_high) begin
            if (line) wait_high <= 1'b0;
          end else if (!line) begin
            state    <= RX_START;
            tick_cnt <= '0;
          end
        end

        RX_START: begin
          if (tick) begin
            if (tick_cnt == HalfLast) begin
              tick_cnt <= '0;
              if (!line) begin
                state   <= RX_DATA;
                bit_idx <= '0;
              end else begin
                state <= RX_IDLE;  // glitch, not a real start bit
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        RX_DATA: begin
          if (tick) begin
            if (tick_cnt == BitLast) begin
              tick_cnt       <= '0;
              shift[bit_idx] <= line;
              if (bit_idx == 3'd7) begin
                state <= RX_STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        RX_STOP: begin
          if (tick) begin
            if (tick_cnt == BitLast) begin
              tick_cnt <= '0;
              state    <= RX_IDLE;
              if (line) begin
                commit <= 1'b1;
              end else begin
                io_input_frame_error <= 1'b1;
                wait_high            <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_input_controller.sv
`timescale 1ns/1ps
module tb_io_input_controller;

  localparam int unsigned CLK_FREQ   = 1600000;
  localparam int unsigned BAUD       = 100000;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned BIT_CLKS   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       TXD;
  logic       ack;
  logic [7:0] value;
  logic       valid;
  logic       overrun;
  logic       frame_error;

  always #5 clk = ~clk;

  io_input_controller #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .TXD                 (TXD),
    .io_input_value      (value),
    .io_input_valid      (valid),
    .io_input_ack        (ack),
    .io_input_overrun    (overrun),
    .io_input_frame_error(frame_error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int seen_cyc = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a byte is presented when valid rises or the value changes while valid.
  logic       valid_prev = 1'b0;
  logic [7:0] value_prev = 8'h00;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (!reset && valid === 1'b1 && (!valid_prev || value !== value_prev)) begin
      seen_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got 0x%0h, required no byte", value);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rx_byte", {24'h0, value}, {24'h0, mon_exp});
      end
    end
    valid_prev = valid;
    value_prev = value;
  end

  task automatic drive_bit(input logic b);
    TXD = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: valid never rose within 40 clk, got %b required 1", name, valid);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1;
    TXD   = 1'b1;
    ack   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_value", {24'h0, value}, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_overrun", {31'h0, overrun}, 32'h0);
    check("reset_frame_error", {31'h0, frame_error}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte and latency from the pin falling edge.
    seen_cyc = 0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_valid("a5_valid");
    lat = seen_cyc - fall_cyc - 1;
    checks++;
    if (lat < 145 || lat > 155) begin
      errors++;
      $display("FAIL a5_latency: got %0d clk, required 145..155 clk", lat);
    end
    check("a5_value", {24'h0, value}, 32'hA5);
    check("a5_overrun", {31'h0, overrun}, 32'h0);
    check("a5_frame_error", {31'h0, frame_error}, 32'h0);
    do_ack();
    check("a5_ack_valid", {31'h0, valid}, 32'h0);

    // Glitch rejection, then a real frame.
    TXD = 1'b0;
    repeat (4) @(negedge clk);
    TXD = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_valid", {31'h0, valid}, 32'h0);
    check("glitch_frame_error", {31'h0, frame_error}, 32'h0);
    check("glitch_overrun", {31'h0, overrun}, 32'h0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_valid("3c_valid");
    check("3c_value", {24'h0, value}, 32'h3C);
    do_ack();

    // Frame error: stop bit low, line held low a while before recovering.
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("fe_valid", {31'h0, valid}, 32'h0);
    check("fe_flag", {31'h0, frame_error}, 32'h1);
    TXD = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    wait_valid("0f_valid");
    check("0f_value", {24'h0, value}, 32'h0F);
    check("fe_sticky", {31'h0, frame_error}, 32'h1);
    do_ack();
    check("fe_cleared", {31'h0, frame_error}, 32'h0);
    check("0f_ack_valid", {31'h0, valid}, 32'h0);

    // Overrun: two back-to-back frames, no ack.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    check("ovr_value", {24'h0, value}, 32'h11);
    check("ovr_valid", {31'h0, valid}, 32'h1);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    do_ack();
    check("ovr_ack_valid", {31'h0, valid}, 32'h0);
    check("ovr_cleared", {31'h0, overrun}, 32'h0);

    // Ack coincident with the commit of the second byte (commit edge is 155 clk after fall).
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    wait_valid("coinc_first_valid");
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (155) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    check("coinc_value", {24'h0, value}, 32'h22);
    check("coinc_valid", {31'h0, valid}, 32'h1);
    check("coinc_overrun", {31'h0, overrun}, 32'h0);

    // Reset during bit 4 of 0xFF while 0x22 is still held.
    TXD = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    TXD = 1'b1;
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_value", {24'h0, value}, 32'h0);
    check("rst_mid_valid", {31'h0, valid}, 32'h0);
    check("rst_mid_overrun", {31'h0, overrun}, 32'h0);
    check("rst_mid_frame_error", {31'h0, frame_error}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10 * BIT_CLKS) @(negedge clk);
    check("rst_no_partial", {31'h0, valid}, 32'h0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_valid("81_valid");
    check("81_value", {24'h0, value}, 32'h81);
    do_ack();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_controller.md
Name: io_input_controller

Overview:
UART receiver (8N1, LSB first) that is the receive-side counterpart of the IO output controller. It deserializes the board's serial input line into bytes and presents each byte to the core through a valid/ack holding register. It sits between the USB-UART pin and the CPU IO bus. An oversampling tick generator provides the bit timing.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit period; must be even and ≥ 4
(derived) TICK_DIV = round(CLK_FREQ / (BAUD*OVERSAMPLE)), minimum 1; equals 54 at the defaults

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
TXD  in  1  serial line from host, idle high, asynchronous to clk
io_input_value  out  8  last received byte, stable while io_input_valid=1
io_input_valid  out  1  byte available
io_input_ack  in  1  consumer takes byte; sampled on a clk edge while valid=1
io_input_overrun  out  1  sticky: a byte was lost because the holding register was full
io_input_frame_error  out  1  sticky: a stop bit was sampled low

Behaviour:
- Reset (asynchronous assert, release synchronous to clk):
  - state=RX_IDLE; value=0; valid=0; overrun=0; frame_error=0.
  - Synchronizer flops preset to 1; tick divider and bit counters cleared.
  - A reset mid-frame aborts the frame; no partial byte is ever delivered.
- Synchronizer: TXD passes through 2 flops before any use. All "line" references below mean the synchronized value, which lags the pin by 2 clk.
- Tick: one-clk pulse every TICK_DIV clk. It runs freely and is restarted (counter to 0) on the idle→start transition, so sampling phase is referenced to the detected falling edge.
- States:
  - RX_IDLE: when line=0, go to RX_START and clear tick_cnt.
  - RX_START: count ticks. At tick OVERSAMPLE/2 (mid start bit), re-sample the line:
    - 0 → RX_DATA, bit_idx=0, tick_cnt=0.
    - 1 → glitch; return to RX_IDLE with no flags set.
  - RX_DATA: every OVERSAMPLE ticks, sample the line into shift[bit_idx] (LSB first). After bit 7, go to RX_STOP.
  - RX_STOP: after OVERSAMPLE ticks, sample the line.
    - 1 → commit the byte.
    - 0 → set frame_error and discard the byte.
    - Either way, return to RX_IDLE. If the line is still 0, the next frame is not detected until the line returns high and then falls again.
- Commit, on the clk after the stop-bit sample:
  - valid=0: value←shift; valid←1.
  - valid=1 and no ack in the same cycle: value unchanged (oldest byte kept); overrun←1.
  - ack and commit in the same cycle: value←new byte; valid stays 1; no overrun.
- Ack:
  - valid=1 and ack=1 with no commit: valid←0 next clk; overrun←0; frame_error←0.
  - ack while valid=0 is ignored; flags are unaffected.
- Latency: valid rises within 2 + OVERSAMPLE/2 + 9*OVERSAMPLE ticks (+1 clk) of the start-bit falling edge at the pin. This is about 9.5 bit times.
- Back-to-back frames with zero idle time between them are received without loss.

Decomposition:
- Package io_uart_pkg holds:
  - typedef enum logic[1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} INPUT_CONTROLLER_STATE;
  - helper function computing TICK_DIV from CLK_FREQ, BAUD and OVERSAMPLE.
- Sub-module io_rx_tick_generator (clk, reset, restart, tick), a parameterised divider. It is kept separate so the TX side can share the same divider style later.

Test Plan:
Bench parameters: CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16 → TICK_DIV=1, so one bit = 16 clk.
- Single byte: drive frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) → value=0xA5, valid=1 at ≤ 155 clk after the falling edge; overrun=0, frame_error=0. Ack one cycle → valid=0 next clk.
- Glitch rejection: pulse TXD low for 4 clk → remains RX_IDLE, valid stays 0, no flags. A following 0x3C frame is received correctly.
- Frame error: send 0x55 with the stop bit held low → valid=0, frame_error=1. Raise TXD, send 0x0F → value=0x0F, valid=1. Ack → frame_error=0.
- Overrun: send 0x11 then 0x22 back-to-back with no ack → value=0x11, valid=1, overrun=1. Ack → valid=0, overrun=0.
- Ack coincident with commit: hold 0x11 valid and assert ack exactly in the 0x22 commit cycle → value=0x22, valid=1, overrun=0.
- Reset mid-frame: assert reset during bit 4 of 0xFF → all outputs 0 immediately (asynchronous). Release reset on an idle line, send 0x81 → value=0x81.
